// File: rtl/control_sequencer_pkg.sv
// control_sequencer_pkg: opcodes, ALU codes, state set and opcode-to-ALU mapping
package control_sequencer_pkg;
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;
  localparam logic [4:0] ALU_NONE = 5'b00000;
  localparam logic [4:0] ALU_ADD  = 5'b00001;
  localparam logic [4:0] ALU_SUB  = 5'b00010;
  localparam logic [4:0] ALU_AND  = 5'b00011;
  localparam logic [4:0] ALU_OR   = 5'b00100;
  localparam logic [4:0] ALU_ROR  = 5'b00101;
  localparam logic [4:0] ALU_ROL  = 5'b00110;
  localparam logic [4:0] ALU_SHR  = 5'b00111;
  localparam logic [4:0] ALU_SHRA = 5'b01000;
  localparam logic [4:0] ALU_SHL  = 5'b01001;
  typedef enum logic [3:0] {S_RESET, S_F0, S_F1, S_F2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALTED} state_t;
  function automatic logic [4:0] alu_code(input logic [4:0] op);
    case (op)
      OP_ADD, OP_ADDI: alu_code = ALU_ADD;
      OP_SUB:          alu_code = ALU_SUB;
      OP_AND, OP_ANDI: alu_code = ALU_AND;
      OP_OR, OP_ORI:   alu_code = ALU_OR;
      OP_ROR:          alu_code = ALU_ROR;
      OP_ROL:          alu_code = ALU_ROL;
      OP_SHR:          alu_code = ALU_SHR;
      OP_SHRA:         alu_code = ALU_SHRA;
      OP_SHL:          alu_code = ALU_SHL;
      default:         alu_code = ALU_NONE;
    endcase
  endfunction
endpackage

// File: rtl/control_sequencer.sv
// control_sequencer: Moore fetch/execute control FSM driving datapath enables and selects
module control_sequencer
  import control_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stop,
  input  logic [31:0] IR_Data,
  input  logic        con_output,
  output logic        run,
  output logic        PC_enable,
  output logic        PC_increment_enable,
  output logic        IR_enable,
  output logic        Y_enable,
  output logic        Z_enable,
  output logic        MAR_enable,
  output logic        MDR_enable,
  output logic        r_enable,
  output logic        con_enable,
  output logic        outport_enable,
  output logic        read,
  output logic        write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        BAout,
  output logic        PC_select,
  output logic        Z_LO_select,
  output logic        MDR_select,
  output logic        c_select,
  output logic        r_select,
  output logic        inport_select,
  output logic [4:0]  alu_instruction
);
  state_t state, state_n;
  logic [4:0] op;
  logic [4:0] ir_op;
  logic unused_ir;
  logic known, is_ld, is_ldi, is_st, is_mem, is_r, is_imm, is_alu, is_br, is_jr, is_in, is_out, is_halt;
  assign ir_op = IR_Data[31:27];
  assign unused_ir = ^IR_Data[26:0];
  assign known = ir_op <= OP_ORI || ir_op == OP_BR || ir_op == OP_JR || ir_op == OP_IN || ir_op == OP_OUT || ir_op == OP_HALT;
  assign is_ld = op == OP_LD;
  assign is_ldi = op == OP_LDI;
  assign is_st = op == OP_ST;
  assign is_mem = is_ld | is_ldi | is_st;
  assign is_r = op >= OP_ADD && op <= OP_SHL;
  assign is_imm = op >= OP_ADDI && op <= OP_ORI;
  assign is_alu = is_r | is_imm;
  assign is_br = op == OP_BR;
  assign is_jr = op == OP_JR;
  assign is_in = op == OP_IN;
  assign is_out = op == OP_OUT;
  assign is_halt = op == OP_HALT;
  // State register; opcode latched at F2 so execute-state outputs depend only on registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_RESET;
      op <= OP_NOP;
    end else begin
      state <= state_n;
      if (state == S_F2) op <= ir_op;
    end
  end
  // Next state and per-state control outputs, everything defaulting to 0
  always_comb begin
    {PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable, MAR_enable, MDR_enable, r_enable,
     con_enable, outport_enable, read, write, Gra, Grb, Grc, BAout, PC_select, Z_LO_select, MDR_select,
     c_select, r_select, inport_select, alu_instruction} = '0;
    run = state != S_RESET && state != S_HALTED;
    state_n = state;
    case (state)
      S_RESET: state_n = S_F0;
      S_F0: begin
        PC_select = 1'b1;
        MAR_enable = 1'b1;
        state_n = stop ? S_HALTED : S_F1;
      end
      S_F1: begin
        PC_increment_enable = 1'b1;
        read = 1'b1;
        MDR_enable = 1'b1;
        state_n = S_F2;
      end
      S_F2: begin
        MDR_select = 1'b1;
        IR_enable = 1'b1;
        state_n = known ? S_T3 : S_F0;
      end
      S_T3: begin
        Grb = is_mem | is_alu;
        BAout = is_mem;
        Y_enable = is_mem | is_alu;
        Gra = is_br | is_jr | is_in | is_out;
        r_select = is_alu | is_br | is_jr | is_out;
        con_enable = is_br;
        PC_enable = is_jr;
        inport_select = is_in;
        r_enable = is_in;
        outport_enable = is_out;
        state_n = is_halt ? S_HALTED : (is_jr | is_in | is_out) ? S_F0 : S_T4;
      end
      S_T4: begin
        c_select = is_mem | is_imm;
        Grc = is_r;
        r_select = is_r;
        alu_instruction = is_alu ? alu_code(op) : is_mem ? ALU_ADD : ALU_NONE;
        Z_enable = is_mem | is_alu;
        PC_select = is_br;
        Y_enable = is_br;
        state_n = S_T5;
      end
      S_T5: begin
        Z_LO_select = !is_br;
        Gra = is_ldi | is_alu;
        r_enable = is_ldi | is_alu;
        MAR_enable = is_ld | is_st;
        c_select = is_br;
        alu_instruction = is_br ? ALU_ADD : ALU_NONE;
        Z_enable = is_br;
        state_n = (is_ldi | is_alu) ? S_F0 : S_T6;
      end
      S_T6: begin
        read = is_ld;
        MDR_enable = is_ld | is_st;
        Gra = is_st;
        r_select = is_st;
        Z_LO_select = is_br;
        PC_enable = is_br & con_output;
        state_n = is_br ? S_F0 : S_T7;
      end
      S_T7: begin
        MDR_select = is_ld;
        Gra = is_ld;
        r_enable = is_ld;
        write = is_st;
        state_n = S_F0;
      end
      S_HALTED: state_n = S_HALTED;
      default: state_n = S_RESET;
    endcase
  end
endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have no parameters; all encodings are package constants.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 stop  in  1  halt request, sampled only in state F0.
REQ-005 IR_Data  in  32  instruction register; opcode = IR_Data[31:27].
REQ-006 con_output  in  1  branch-condition flag from the datapath CON logic.
REQ-007 run  out  1  high while executing, low when halted.
REQ-008 PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable, MAR_enable, MDR_enable, r_enable, con_enable, outport_enable  out  1 each  register load enables.
REQ-009 read, write  out  1 each  memory read and memory write strobes.
REQ-010 Gra, Grb, Grc, BAout  out  1 each  register select/encode controls.
REQ-011 PC_select, Z_LO_select, MDR_select, c_select, r_select, inport_select  out  1 each  bus source selects.
REQ-012 alu_instruction  out  5  ALU opcode; 0 when the ALU is unused.

Function
REQ-013 Moore FSM, one state per clk; outputs SHALL depend only on the registered state, and any signal not listed for a state SHALL be 0.
REQ-014 Fetch: F0 {PC_select, MAR_enable}; F1 {PC_increment_enable, read, MDR_enable}; F2 {MDR_select, IR_enable}; F2 SHALL be followed by T3 of the decoded opcode.
REQ-015 ldi (00001): T3 {Grb, BAout, Y_enable}; T4 {c_select, alu_instruction=ALU_ADD(00001), Z_enable}; T5 {Z_LO_select, Gra, r_enable}.
REQ-016 ld (00000): T3, T4 as ldi; T5 {Z_LO_select, MAR_enable}; T6 {read, MDR_enable}; T7 {MDR_select, Gra, r_enable}.
REQ-017 st (00010): T3–T5 as ld; T6 {Gra, r_select, MDR_enable, read=0}; T7 {write}.
REQ-018 R-type ALU ops (00011–01011): T3 {Grb, r_select, Y_enable}; T4 {Grc, r_select, alu_instruction=ALU code mapped from the opcode via the package table, Z_enable}; T5 {Z_LO_select, Gra, r_enable}.
REQ-019 addi/andi/ori (01100–01110): T3 as R-type; T4 {c_select, mapped ALU code, Z_enable}; T5 as R-type.
REQ-020 br (10011): T3 {Gra, r_select, con_enable}; T4 {PC_select, Y_enable}; T5 {c_select, ALU_ADD, Z_enable}; T6 {Z_LO_select, PC_enable = con_output sampled in T6}.
REQ-021 jr (10100): T3 {Gra, r_select, PC_enable}.
REQ-022 in (10110): T3 {inport_select, Gra, r_enable}.
REQ-023 out (10111): T3 {Gra, r_select, outport_enable}.
REQ-024 nop (11010) and every unlisted opcode SHALL return F2→F0 with no execute states.
REQ-025 The last execute state of every instruction SHALL be followed by F0.
REQ-026 Instruction latencies in cycles, F0 through last state: nop 3, jr/in/out 4, ALU/ldi 6, br 7, ld/st 8.
REQ-027 halt (11011) at T3, or stop=1 in F0, SHALL enter HALTED: all outputs 0 and run=0. HALTED SHALL be left only by reset.
REQ-028 read and write SHALL never be asserted in the same cycle.

Reset
REQ-029 reset=1 at a clock edge SHALL force state RESET, with all outputs 0 and run=0 in the following cycle, regardless of the current state, including mid-instruction or HALTED.
REQ-030 The first cycle after reset deasserts SHALL be F0 with run=1.

Structure
REQ-031 A shared package SHALL hold the opcode constants, the ALU code constants (ALU_ADD=00001), the state enumeration and the opcode-to-ALU-code function.
REQ-032 The block SHALL be a single module with no sub-modules; the decode function SHALL be taken from the package.

Verification
REQ-033 Reset, then IR_Data=ldi (0x08800065): F0, F1, F2, T3, T4, T5 outputs exactly per REQ-014/015; T4 alu_instruction=00001; back in F0 at cycle 7.
REQ-034 ld, then st: MAR_enable in F0 and T5; read in F1 and T6 (ld); write only in T7 (st); 8 cycles each.
REQ-035 br with con_output=0 and then con_output=1: PC_enable in T6 equals 0 and then 1; 7 cycles each.
REQ-036 out, then unknown opcode 11111: outport_enable only in T3 of out; the unknown opcode returns to F0 after 3 cycles with no enables.
REQ-037 halt: run=0 and all outputs 0 for 20+ cycles; stop=1 in F0 also halts; reset pulse restarts at F0.
REQ-038 Reset asserted in T6 of ld: next cycle all outputs 0; then F0 with run=1.
